param_priv_pipeline_controller: RTL

Parametrised stall/flush controller for N-stage privileged in-order cores. It is the successor to the fixed seven-stage privileged stall unit.
- Generalises per-stage back-pressure, bubble insertion and redirect flushes to any NUM_STAGES.
- Adds a sequenced trap-flush FSM and a solo-instruction drain/serialise FSM with timeout.
- Sits between hazard detection and all pipeline registers.

---
 rtl/param_priv_pipeline_controller_if.sv | 29 ++
 rtl/param_priv_pipeline_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/param_priv_pipeline_controller_if.sv
// Hazard-unit <-> pipeline controller bundle: per-stage status in,
// per-stage stall/flush out.
interface param_priv_pipeline_controller_if #(
    parameter int NUM_STAGES = 7,
    parameter int SW = $clog2(NUM_STAGES)
);
    logic [NUM_STAGES-1:0] stage_hazard;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  redirect_req;
    logic [SW-1:0]         redirect_stage;
    logic                  trap_req;
    logic                  solo_req;
    logic                  solo_retire;
    logic                  clog;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush;

    modport master (
        output stage_hazard, stage_valid, redirect_req, redirect_stage,
        output trap_req, solo_req, solo_retire, clog,
        input  stall, flush
    );

    modport slave (
        input  stage_hazard, stage_valid, redirect_req, redirect_stage,
        input  trap_req, solo_req, solo_retire, clog,
        output stall, flush
    );
endinterface

// File: rtl/param_priv_pipeline_controller.sv
// N-stage stall/flush controller with trap-flush and solo-drain FSMs.
// Optional perf counters enabled by defining PRIV_PIPE_PERF_EN.
module param_priv_pipeline_controller #(
    parameter int CORE              = 0,
    parameter int NUM_STAGES        = 7,
    parameter int SOLO_STAGE        = 2,
    parameter int TRAP_FLUSH_CYCLES = 2,
    parameter int SOLO_TIMEOUT      = 255,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    param_priv_pipeline_controller_if.slave pc,
    output logic [1:0]           state,
    output logic                 solo_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_cycles,
    output logic [CNT_WIDTH-1:0] solo_cycles
);
    localparam int SW = $clog2(NUM_STAGES);
    localparam int TW = $clog2(TRAP_FLUSH_CYCLES + 1);
    localparam int XW = $clog2(SOLO_TIMEOUT + 1);
    localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        TRAP_FLUSH = 2'd1,
        SOLO_DRAIN = 2'd2,
        SOLO_EXEC  = 2'd3
    } state_t;

    state_t cur, nxt;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [XW-1:0] xcnt, xcnt_n;
    logic          to_n;

    logic [SW-1:0]         rs;
    logic [NUM_STAGES-1:0] base_stall, rmask;
    logic [NUM_STAGES-1:0] stall_v, flush_v, force_f;
    logic                  solo_go, redir_ok, drain, older_empty;

    logic [31:0] unused_core;
    logic        unused_valid;
    assign unused_core  = 32'(CORE);
    assign unused_valid = ^pc.stage_valid[SOLO_STAGE:0];

    assign rs = (pc.redirect_stage > LAST) ? LAST : pc.redirect_stage;
    assign older_empty = pc.stage_valid[NUM_STAGES-1:SOLO_STAGE+1] == '0;

    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            acc           = acc | pc.stage_hazard[i];
            base_stall[i] = acc;
            rmask[i]      = SW'(i) < rs;
        end
    end

    // A drain redirect only counts when it kills stages past the solo slot.
    assign solo_go = (cur == IDLE) & pc.solo_req & ~pc.trap_req
                   & ~pc.redirect_req;
    assign redir_ok = pc.redirect_req & ((cur == IDLE) | (cur == SOLO_EXEC)
                    | ((cur == SOLO_DRAIN) & (rs > SW'(SOLO_STAGE))));
    assign drain = ((cur == SOLO_DRAIN) & ~redir_ok) | solo_go;

    always_comb begin
        stall_v    = base_stall;
        stall_v[0] = base_stall[0] & ~pc.clog;
        force_f    = '0;
        if (drain) begin
            for (int i = 0; i <= SOLO_STAGE; i++) stall_v[i] = 1'b1;
            force_f[SOLO_STAGE+1] = 1'b1;
        end
        if (cur == SOLO_EXEC) begin
            for (int i = 0; i < SOLO_STAGE; i++) stall_v[i] = 1'b1;
            if (xcnt != '0) force_f[SOLO_STAGE] = 1'b1;
        end
        if (redir_ok) begin
            stall_v = stall_v & ~rmask;
            force_f = force_f | rmask;
        end
        flush_v = force_f;
        for (int i = 0; i < NUM_STAGES - 1; i++)
            flush_v[i+1] = flush_v[i+1] | (stall_v[i] & ~stall_v[i+1]);
        if (!reset || pc.trap_req || cur == TRAP_FLUSH) begin
            stall_v = '0;
            flush_v = '1;
        end
    end

    assign pc.stall = stall_v;
    assign pc.flush = flush_v;

    always_comb begin
        nxt    = cur;
        tcnt_n = tcnt;
        xcnt_n = xcnt;
        to_n   = 1'b0;
        if (pc.trap_req) begin
            nxt    = TRAP_FLUSH;
            tcnt_n = TW'(TRAP_FLUSH_CYCLES);
        end else begin
            unique case (cur)
                IDLE: if (solo_go) nxt = SOLO_DRAIN;
                TRAP_FLUSH: begin
                    if (tcnt <= TW'(1)) nxt = IDLE;
                    else tcnt_n = tcnt - TW'(1);
                end
                SOLO_DRAIN: begin
                    if (redir_ok) begin
                        nxt = IDLE;
                    end else if (older_empty) begin
                        nxt    = SOLO_EXEC;
                        xcnt_n = '0;
                    end
                end
                SOLO_EXEC: begin
                    if (pc.solo_retire) begin
                        nxt = IDLE;
                    end else if (xcnt == XW'(SOLO_TIMEOUT - 1)) begin
                        nxt  = IDLE;
                        to_n = 1'b1;
                    end else begin
                        xcnt_n = xcnt + XW'(1);
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur          <= IDLE;
            tcnt         <= '0;
            xcnt         <= '0;
            solo_timeout <= 1'b0;
        end else begin
            cur          <= nxt;
            tcnt         <= tcnt_n;
            xcnt         <= xcnt_n;
            solo_timeout <= to_n;
        end
    end

    assign state = cur;

`ifdef PRIV_PIPE_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
            solo_cycles  <= '0;
        end else begin
            if (|stall_v && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (|flush_v && flush_cycles != '1)
                flush_cycles <= flush_cycles + CNT_WIDTH'(1);
            if ((cur == SOLO_DRAIN || cur == SOLO_EXEC) && solo_cycles != '1)
                solo_cycles <= solo_cycles + CNT_WIDTH'(1);
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
    assign solo_cycles  = '0;
`endif
endmodule
